uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: trigger-select encodings,
// status bit positions and the receive-timeout state type.
package uart_pkg;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } trig_sel_e;

    localparam int STAT_LEVEL   = 0;
    localparam int STAT_PARITY  = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_TIMEOUT = 3;

    typedef enum logic [1:0] {
        TO_IDLE    = 2'b00,
        TO_COUNT   = 2'b01,
        TO_EXPIRED = 2'b10
    } to_state_e;

    function automatic int unsigned trig_level(input logic [1:0] sel, input int unsigned depth);
        int unsigned lvl;
        case (sel)
            TRIG_ONE:     lvl = 1;
            TRIG_QUARTER: lvl = depth / 4;
            TRIG_HALF:    lvl = depth / 2;
            default:      lvl = depth - 2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO storage: first-word fall-through from registered storage, pointers
// wrap modulo DEPTH. Push/pop qualification (full, flush priority) lives in the caller.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads 8'h00 until the first push.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: RX FIFO front end, sticky error flags, trigger level and
// interrupt. The character-timeout FSM is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TO_BITS    = 40
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_en_i,
    input  logic [15:0]                   cfg_div_i,
    input  logic [1:0]                    cfg_trig_i,
    input  logic [3:0]                    irq_en_i,
    input  logic                          flush_i,
    input  logic                          clr_i,
    input  logic                          rx_valid_i,
    input  logic [7:0]                    rx_data_i,
    output logic                          rx_ready_o,
    input  logic                          rx_busy_i,
    input  logic                          rx_err_i,
    output logic                          rx_err_clr_o,
    output logic                          rd_valid_o,
    output logic [7:0]                    rd_data_o,
    input  logic                          rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [3:0]                    status_o,
    output logic                          irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          push_req, push, pop, full, ovr_set, level_hit, timeout;
    logic          ovr_q, ovr_d, par_q, par_d;
    logic          err_seen_q, err_clr_q, err_clr_d;
    logic          irq_q, irq_d;
    logic [LW-1:0] level;

    assign rx_ready_o = cfg_en_i & rstn_i;
    assign push_req   = rx_valid_i & rx_ready_o;
    assign full       = (level == LW'(FIFO_DEPTH));
    assign rd_valid_o = (level != '0);
    assign pop        = rd_valid_o & rd_ready_i & ~flush_i;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push       = push_req & ~flush_i & (~full | pop);
    assign ovr_set    = push_req & ~flush_i & full & ~pop;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (rx_data_i),
        .rdata_o (rd_data_o),
        .level_o (level)
    );

    assign level_o   = level;
    assign level_hit = (level >= LW'(trig_level(cfg_trig_i, FIFO_DEPTH)));

    always_comb begin
        status_o               = '0;
        status_o[STAT_LEVEL]   = level_hit;
        status_o[STAT_PARITY]  = par_q;
        status_o[STAT_OVERRUN] = ovr_q;
        status_o[STAT_TIMEOUT] = timeout;
    end

    always_comb begin
        ovr_d     = ovr_set | (ovr_q & ~clr_i);
        par_d     = rx_err_i | (par_q & ~clr_i);
        err_clr_d = rx_err_i & ~err_seen_q;
        irq_d     = |(status_o & irq_en_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovr_q      <= 1'b0;
            par_q      <= 1'b0;
            err_seen_q <= 1'b0;
            err_clr_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ovr_q      <= ovr_d;
            par_q      <= par_d;
            err_seen_q <= rx_err_i;
            err_clr_q  <= err_clr_d;
            irq_q      <= irq_d;
        end
    end

    assign rx_err_clr_o = err_clr_q;
    assign irq_o        = irq_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int BW = $clog2(TO_BITS) + 1;

    to_state_e     state_q, state_d;
    logic [15:0]   presc_q, presc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          activity;

    assign activity = push | pop | flush_i;

    // Any FIFO activity restarts the idle period, so COUNT is only entered on a quiet cycle.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        bit_d   = '0;
        if (!cfg_en_i) begin
            state_d = TO_IDLE;
        end else begin
            case (state_q)
                TO_IDLE: begin
                    if ((level != '0) && !rx_busy_i && !activity) state_d = TO_COUNT;
                end
                TO_COUNT: begin
                    if (activity || rx_busy_i || (level == '0)) begin
                        state_d = TO_IDLE;
                    end else if (presc_q == cfg_div_i) begin
                        if (bit_q == BW'(TO_BITS - 1)) state_d = TO_EXPIRED;
                        else bit_d = bit_q + BW'(1);
                    end else begin
                        presc_d = presc_q + 16'd1;
                        bit_d   = bit_q;
                    end
                end
                TO_EXPIRED: begin
                    if (activity) state_d = TO_IDLE;
                end
                default: state_d = TO_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= TO_IDLE;
            presc_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
        end
    end

    assign timeout = (state_q == TO_EXPIRED);
`else
    localparam int unused_to_bits = TO_BITS;
    logic unused_inputs;
    assign unused_inputs = ^{rx_busy_i, cfg_div_i, unused_to_bits[0]};
    assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int TOB   = 40;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_en, flush, clr, rx_valid, rx_busy, rx_err, rd_ready;
    logic [15:0]   cfg_div;
    logic [1:0]    cfg_trig;
    logic [3:0]    irq_en;
    logic [7:0]    rx_data;
    logic          rx_ready, rx_err_clr, rd_valid, irq;
    logic [7:0]    rd_data;
    logic [LW-1:0] level;
    logic [3:0]    status;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TO_BITS(TOB)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .cfg_en_i     (cfg_en),
        .cfg_div_i    (cfg_div),
        .cfg_trig_i   (cfg_trig),
        .irq_en_i     (irq_en),
        .flush_i      (flush),
        .clr_i        (clr),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .rx_busy_i    (rx_busy),
        .rx_err_i     (rx_err),
        .rx_err_clr_o (rx_err_clr),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .rd_ready_i   (rd_ready),
        .level_o      (level),
        .status_o     (status),
        .irq_o        (irq)
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state
    byte unsigned mq[$];
    bit  mOvr, mPar, mErrPrev, mTmo;
    int  mIdleCnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int trigOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    function automatic logic [3:0] modelStatus();
        return {mTmo, mOvr, mPar, (mq.size() >= trigOf(cfg_trig))};
    endfunction

    task automatic modelReset();
        mq.delete();
        mOvr = 0; mPar = 0; mErrPrev = 0; mTmo = 0; mIdleCnt = 0;
    endtask

    task automatic setQuiet();
        rx_valid = 0; rd_ready = 0; flush = 0; clr = 0; rx_err = 0;
    endtask

    // One clock: advance the model on the current inputs, then compare after the edge.
    task automatic applyStimulus();
        bit pushReq, pushAcc, doPop, ovrSet, expIrq, expErrClr;
        int toLimit;
        expIrq    = |(modelStatus() & irq_en);
        expErrClr = rx_err && !mErrPrev;
        pushReq   = rx_valid && cfg_en;
        doPop     = !flush && (mq.size() != 0) && rd_ready;
        pushAcc   = pushReq && !flush && ((mq.size() < DEPTH) || doPop);
        ovrSet    = pushReq && !flush && !pushAcc;
        toLimit   = 1 + TOB * (int'(cfg_div) + 1);
`ifdef UART_RX_TIMEOUT_EN
        if (!cfg_en || flush || pushAcc || doPop) begin
            mTmo = 0; mIdleCnt = 0;
        end else if (!mTmo) begin
            if (!rx_busy && mq.size() != 0) begin
                mIdleCnt++;
                if (mIdleCnt >= toLimit) mTmo = 1;
            end else begin
                mIdleCnt = 0;
            end
        end
`else
        toLimit = 0;
`endif
        if (flush) mq.delete();
        else begin
            if (doPop) void'(mq.pop_front());
            if (pushAcc) mq.push_back(rx_data);
        end
        mOvr     = ovrSet || (mOvr && !clr);
        mPar     = rx_err || (mPar && !clr);
        mErrPrev = rx_err;
        @(posedge clk); #1;
        checkOutput("level", level, mq.size());
        checkOutput("rd_valid", rd_valid, mq.size() != 0);
        if (mq.size() != 0) checkOutput("rd_data", rd_data, mq[0]);
        checkOutput("status", status, modelStatus());
        checkOutput("irq", irq, expIrq);
        checkOutput("rx_ready", rx_ready, cfg_en);
        checkOutput("err_clr", rx_err_clr, expErrClr);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rx_ready"}, rx_ready, 0);
        checkOutput({tag, "_err_clr"}, rx_err_clr, 0);
        checkOutput({tag, "_rd_valid"}, rd_valid, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 8'h00);
        checkOutput({tag, "_level"}, level, 0);
        checkOutput({tag, "_status"}, status, 0);
        checkOutput({tag, "_irq"}, irq, 0);
    endtask

    task automatic pushByte(input logic [7:0] b);
        rx_valid = 1; rx_data = b;
        applyStimulus();
        rx_valid = 0;
    endtask

    initial begin
        int firstRise, irqRise, pulses;
        rstn = 0; cfg_en = 1; cfg_div = 16'd3; cfg_trig = 2'b00; irq_en = 4'b0000;
        rx_busy = 1; rx_data = 8'h00;
        setQuiet();
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk); rstn = 1;

        // Two bytes in, two out, in order
        pushByte(8'hA5);
        checkOutput("fwft_valid", rd_valid, 1);
        pushByte(8'h3C);
        checkOutput("two_level", level, 2);
        checkOutput("two_head", rd_data, 8'hA5);
        rd_ready = 1;
        applyStimulus();
        checkOutput("two_head2", rd_data, 8'h3C);
        applyStimulus();
        rd_ready = 0;
        checkOutput("two_empty", level, 0);

        // Overrun on the 17th byte, cleared by clr
        for (int i = 0; i < 17; i++) pushByte(8'(i + 1));
        checkOutput("ovr_level", level, DEPTH);
        checkOutput("ovr_flag", status[2], 1);
        checkOutput("ovr_head", rd_data, 8'h01);
        clr = 1; applyStimulus(); clr = 0;
        checkOutput("ovr_cleared", status[2], 0);

        // Full FIFO, push and pop in the same cycle
        rx_valid = 1; rx_data = 8'h77; rd_ready = 1;
        applyStimulus();
        setQuiet();
        checkOutput("pp_level", level, DEPTH);
        checkOutput("pp_no_ovr", status[2], 0);
        rd_ready = 1;
        repeat (DEPTH) applyStimulus();
        rd_ready = 0;

        // Trigger at a quarter, then flush drops a same-cycle push
        cfg_trig = 2'b01;
        for (int i = 0; i < 4; i++) pushByte(8'(8'h40 + i));
        checkOutput("trig_hit", status[0], 1);
        flush = 1; rx_valid = 1; rx_data = 8'hEE;
        applyStimulus();
        setQuiet();
        checkOutput("flush_level", level, 0);
        pushByte(8'h11);
        checkOutput("flush_dropped", rd_data, 8'h11);
        rd_ready = 1; applyStimulus(); rd_ready = 0;
        cfg_trig = 2'b00;

        // Parity error held for five cycles produces one clear pulse
        irq_en = 4'b0010; pulses = 0; rx_err = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            if (rx_err_clr) pulses++;
        end
        rx_err = 0;
        repeat (2) applyStimulus();
        checkOutput("par_flag", status[1], 1);
        checkOutput("par_pulses", pulses, 1);
        clr = 1; applyStimulus(); clr = 0;
        applyStimulus();
        checkOutput("par_cleared", status[1], 0);

        // Character timeout with a single byte and divisor 3
        irq_en = 4'b1000; rx_busy = 0; cfg_div = 16'd3;
        firstRise = 0; irqRise = 0;
        pushByte(8'h5A);
        for (int k = 1; k <= 165; k++) begin
            applyStimulus();
            if (status[3] && firstRise == 0) firstRise = k;
            if (irq && irqRise == 0) irqRise = k;
        end
`ifdef UART_RX_TIMEOUT_EN
        checkOutput("tmo_rise", firstRise, 161);
        checkOutput("tmo_irq", irqRise, 162);
`else
        checkOutput("tmo_absent", firstRise, 0);
        checkOutput("tmo_irq_absent", irqRise, 0);
`endif
        rd_ready = 1; applyStimulus(); rd_ready = 0;
        checkOutput("tmo_pop_clear", status[3], 0);
        applyStimulus();
        checkOutput("tmo_irq_clear", irq, 0);
        rx_busy = 1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cfg_en   = ($urandom_range(0, 9) != 0);
            rx_valid = $urandom_range(0, 1);
            rx_data  = 8'($urandom);
            rd_ready = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 40) == 0);
            clr      = ($urandom_range(0, 20) == 0);
            rx_err   = ($urandom_range(0, 15) == 0);
            rx_busy  = ($urandom_range(0, 3) != 0);
            cfg_div  = 16'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) cfg_trig = 2'($urandom);
            if ($urandom_range(0, 31) == 0) irq_en = 4'($urandom);
            applyStimulus();
        end
        setQuiet();
        cfg_en = 1; rx_busy = 1; cfg_trig = 2'b00; irq_en = 4'b0000;
        applyStimulus();

        // Asynchronous reset in the middle of filling
        for (int i = 0; i < 5; i++) pushByte(8'(8'h90 + i));
        #2 rstn = 0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        @(negedge clk); rstn = 1;
        applyStimulus();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
